// File: rtl/viterbi_pkg.sv
// viterbi_pkg
//   Shared helpers for the rate-1/2 hard-decision Viterbi decoder.
//   - ns_of()   : number of trellis states for a constraint length.
//   - bm()      : Hamming distance between two 2-bit symbols (0..2).
//   - enc_out() : convolutional encoder output {c0,c1} for a given state
//                 and input bit; the state is {u_t-1 .. u_t-K+1}, newest
//                 bit at the MSB.
package viterbi_pkg;

  // Largest supported constraint length; helpers work on this fixed width.
  localparam int K_MAX = 7;

  function automatic int ns_of(input int k);
    return 1 << (k - 1);
  endfunction

  function automatic logic [1:0] bm(input logic [1:0] rx, input logic [1:0] ex);
    logic [1:0] d;
    d = rx ^ ex;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  // Shift vector s = {u, state}: the input bit lands at position k-1 so
  // generator bit K-1 taps the newest input.
  function automatic logic [1:0] enc_out(input logic [K_MAX-2:0] state,
                                         input logic             u,
                                         input logic [K_MAX-1:0] g0,
                                         input logic [K_MAX-1:0] g1,
                                         input int               k);
    logic [K_MAX-1:0] s;
    s      = K_MAX'(state);
    s[k-1] = u;
    return {^(s & g0), ^(s & g1)};
  endfunction

endpackage

// File: rtl/viterbi_decoder_r2_acs.sv
// viterbi_acs_unit
//   Add-compare-select for one trellis state.
//   Ports:
//     i_metric_a/b : path metrics of predecessors pa / pb
//     i_bm_a/b     : branch metrics of the pa->ns / pb->ns transitions
//     i_path_a/b   : stored survivor tails of pa / pb (oldest bit at MSB)
//     i_bit        : information bit implied by entering this state
//     o_metric     : saturated metric of the surviving candidate
//     o_path       : full new survivor {selected tail, i_bit}
module viterbi_acs_unit #(
  parameter int METRIC_W = 6,
  parameter int TB_DEPTH = 15
) (
  input  logic [METRIC_W-1:0] i_metric_a,
  input  logic [METRIC_W-1:0] i_metric_b,
  input  logic [1:0]          i_bm_a,
  input  logic [1:0]          i_bm_b,
  input  logic [TB_DEPTH-2:0] i_path_a,
  input  logic [TB_DEPTH-2:0] i_path_b,
  input  logic                i_bit,
  output logic [METRIC_W-1:0] o_metric,
  output logic [TB_DEPTH-1:0] o_path
);

  function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] m,
                                                  input logic [1:0]          b);
    logic [METRIC_W:0] s;
    s = {1'b0, m} + {{(METRIC_W-1){1'b0}}, b};
    return s[METRIC_W] ? '1 : s[METRIC_W-1:0];
  endfunction

  logic [METRIC_W-1:0] w_cand_a;
  logic [METRIC_W-1:0] w_cand_b;
  logic                w_sel;

  assign w_cand_a = sat_add(i_metric_a, i_bm_a);
  assign w_cand_b = sat_add(i_metric_b, i_bm_b);
  // Strict compare: a tie keeps the pa branch.
  assign w_sel    = (w_cand_b < w_cand_a);
  assign o_metric = w_sel ? w_cand_b : w_cand_a;
  assign o_path   = {(w_sel ? i_path_b : i_path_a), i_bit};

endmodule

// File: rtl/viterbi_decoder_r2.sv
// viterbi_decoder_r2
//   Streaming hard-decision Viterbi decoder, rate 1/2, register-exchange
//   survivor memory of depth TB_DEPTH. Emits one decoded bit per accepted
//   symbol once TB_DEPTH symbols have been seen since reset.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     in_valid     : in_sym accepted this cycle (no backpressure)
//     in_sym       : received symbol, [1] = c0, [0] = c1
//     out_valid    : single-cycle pulse per decoded bit
//     out_bit      : decoded information bit, oldest first
//     best_metric  : metric of the current best state
module viterbi_decoder_r2
  import viterbi_pkg::*;
#(
  parameter int             K        = 3,
  parameter logic [K-1:0]   G0       = 3'b111,
  parameter logic [K-1:0]   G1       = 3'b101,
  parameter int             TB_DEPTH = 15,
  parameter int             METRIC_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [1:0]          in_sym,
  output logic                out_valid,
  output logic                out_bit,
  output logic [METRIC_W-1:0] best_metric
);

  localparam int NS    = ns_of(K);
  localparam int SW    = K - 1;
  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [METRIC_W-1:0] BIAS = {1'b1, {(METRIC_W-1){1'b0}}};

  // Survivors keep only TB_DEPTH-1 bits: the oldest bit of each new path
  // is either emitted straight away (best state) or discarded.
  logic [METRIC_W-1:0] r_metric [NS];
  logic [TB_DEPTH-2:0] r_path   [NS];
  logic [CNT_W-1:0]    r_cnt;
  logic                r_out_valid;
  logic                r_out_bit;
  logic [METRIC_W-1:0] r_best_metric;

  logic [METRIC_W-1:0] w_cand     [NS];
  logic [METRIC_W-1:0] w_metric_n [NS];
  logic [TB_DEPTH-1:0] w_path_n   [NS];
  logic                w_norm;
  logic [SW-1:0]       w_best;
  logic [METRIC_W-1:0] w_best_m;
  logic                w_out_bit;

  // ACS stage: predecessors of ns are {ns[K-3:0],0} and {ns[K-3:0],1};
  // the input bit that leads into ns is ns[K-2].
  for (genvar g = 0; g < NS; g++) begin : g_acs
    localparam int   PA_I = (g * 2) % NS;
    localparam int   PB_I = PA_I + 1;
    localparam logic U    = (g >= NS / 2);

    logic [1:0] w_bm_a;
    logic [1:0] w_bm_b;

    assign w_bm_a = bm(in_sym, enc_out((K_MAX-1)'(PA_I), U, K_MAX'(G0), K_MAX'(G1), K));
    assign w_bm_b = bm(in_sym, enc_out((K_MAX-1)'(PB_I), U, K_MAX'(G0), K_MAX'(G1), K));

    viterbi_acs_unit #(
      .METRIC_W (METRIC_W),
      .TB_DEPTH (TB_DEPTH)
    ) u_acs (
      .i_metric_a (r_metric[PA_I]),
      .i_metric_b (r_metric[PB_I]),
      .i_bm_a     (w_bm_a),
      .i_bm_b     (w_bm_b),
      .i_path_a   (r_path[PA_I]),
      .i_path_b   (r_path[PB_I]),
      .i_bit      (U),
      .o_metric   (w_cand[g]),
      .o_path     (w_path_n[g])
    );
  end

  // Normalisation and best-state search on the new metrics.
  always_comb begin
    w_norm = 1'b1;
    for (int i = 0; i < NS; i++) begin
      w_norm = w_norm & w_cand[i][METRIC_W-1];
    end
    // Every MSB set: subtracting 2^(METRIC_W-1) is just clearing the MSB.
    for (int i = 0; i < NS; i++) begin
      w_metric_n[i] = w_norm ? {1'b0, w_cand[i][METRIC_W-2:0]} : w_cand[i];
    end
    w_best   = '0;
    w_best_m = w_metric_n[0];
    // Strict less-than keeps the lowest index on ties.
    for (int i = 1; i < NS; i++) begin
      if (w_metric_n[i] < w_best_m) begin
        w_best_m = w_metric_n[i];
        w_best   = SW'(i);
      end
    end
  end

  assign w_out_bit = w_path_n[w_best][TB_DEPTH-1];

  // State/output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        r_metric[i] <= (i == 0) ? '0 : BIAS;
        r_path[i]   <= '0;
      end
      r_cnt         <= '0;
      r_out_valid   <= 1'b0;
      r_out_bit     <= 1'b0;
      r_best_metric <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (in_valid) begin
        for (int i = 0; i < NS; i++) begin
          r_metric[i] <= w_metric_n[i];
          r_path[i]   <= w_path_n[i][TB_DEPTH-2:0];
        end
        if (r_cnt != CNT_W'(TB_DEPTH)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        // This acceptance is symbol r_cnt+1; valid once that reaches TB_DEPTH.
        r_out_valid   <= (r_cnt >= CNT_W'(TB_DEPTH - 1));
        r_out_bit     <= w_out_bit;
        r_best_metric <= w_best_m;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_bit     = r_out_bit;
  assign best_metric = r_best_metric;

endmodule
